// File: rtl/fht_but_array.sv
// Pipelined array of BUT_NUM radix-2 Hartley butterflies: multiply, round, add/sub,
// optional halving, saturation and output reordering over three enabled stages.
module fht_but_array #(
    parameter int D_BIT   = 17,
    parameter int W_BIT   = 12,
    parameter int BUT_NUM = 2
) (
    input  logic                           iCLK,
    input  logic                           iRESET,
    input  logic                           iEN,
    input  logic                           iVALID,
    input  logic                           iSCALE,
    input  logic                           iORDER,
    input  logic [BUT_NUM*D_BIT-1:0]       iA,
    input  logic [BUT_NUM*D_BIT-1:0]       iB,
    input  logic [BUT_NUM*D_BIT-1:0]       iC,
    input  logic [BUT_NUM*W_BIT-1:0]       iCOS,
    input  logic [BUT_NUM*W_BIT-1:0]       iSIN,
    input  logic                           iOVF_CLR,
    output logic                           oVALID,
    output logic [2*BUT_NUM*D_BIT-1:0]     oY,
    output logic                           oOVF
);

    localparam int PW = D_BIT + W_BIT + 1;
    localparam int TW = D_BIT + 3;
    localparam int SW = D_BIT + 4;
    localparam int YW = 2 * BUT_NUM * D_BIT;
    localparam logic signed [SW-1:0] SMAX = SW'((2 ** (D_BIT - 1)) - 1);
    localparam logic signed [SW-1:0] SMIN = ~SMAX;
    localparam logic signed [PW-1:0] RND  = PW'(2 ** (W_BIT - 3));

    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic scale1_q, scale1_d, order1_q, order1_d;
    logic scale2_q, scale2_d, order2_q, order2_d;
    logic ld1, ld2, ld3;
    logic signed [PW-1:0]    prod_q [BUT_NUM];
    logic signed [PW-1:0]    prod_d [BUT_NUM];
    logic signed [D_BIT-1:0] a1_q   [BUT_NUM];
    logic signed [D_BIT-1:0] a1_d   [BUT_NUM];
    logic signed [D_BIT-1:0] a2_q   [BUT_NUM];
    logic signed [D_BIT-1:0] a2_d   [BUT_NUM];
    logic signed [TW-1:0]    t_q    [BUT_NUM];
    logic signed [TW-1:0]    t_d    [BUT_NUM];
    logic signed [PW-1:0]    rnd    [BUT_NUM];
    logic signed [SW-1:0]    s0     [BUT_NUM];
    logic signed [SW-1:0]    s1     [BUT_NUM];
    logic [BUT_NUM-1:0]      sat;
    logic [YW-1:0]           y_q, y_d;
    logic                    ovf_q, ovf_d;

    function automatic logic out_of_range(input logic signed [SW-1:0] v);
        return (v > SMAX) || (v < SMIN);
    endfunction

    function automatic logic [D_BIT-1:0] clamp(input logic signed [SW-1:0] v);
        if (v > SMAX) return SMAX[D_BIT-1:0];
        if (v < SMIN) return SMIN[D_BIT-1:0];
        return D_BIT'(v);
    endfunction

    always_comb begin
        ld1      = iEN & iVALID;
        v1_d     = iEN ? iVALID : v1_q;
        scale1_d = ld1 ? iSCALE : scale1_q;
        order1_d = ld1 ? iORDER : order1_q;
        for (int unsigned k = 0; k < BUT_NUM; k++) begin
            prod_d[k] = prod_q[k];
            a1_d[k]   = a1_q[k];
            if (ld1) begin
                prod_d[k] = PW'($signed(iB[k*D_BIT +: D_BIT])) * PW'($signed(iCOS[k*W_BIT +: W_BIT]))
                          + PW'($signed(iC[k*D_BIT +: D_BIT])) * PW'($signed(iSIN[k*W_BIT +: W_BIT]));
                a1_d[k]   = $signed(iA[k*D_BIT +: D_BIT]);
            end
        end
    end

    // Round half up by biasing before the arithmetic shift.
    always_comb begin
        ld2      = iEN & v1_q;
        v2_d     = iEN ? v1_q : v2_q;
        scale2_d = ld2 ? scale1_q : scale2_q;
        order2_d = ld2 ? order1_q : order2_q;
        for (int unsigned k = 0; k < BUT_NUM; k++) begin
            rnd[k]  = prod_q[k] + RND;
            t_d[k]  = t_q[k];
            a2_d[k] = a2_q[k];
            if (ld2) begin
                t_d[k]  = TW'(rnd[k] >>> (W_BIT - 2));
                a2_d[k] = a1_q[k];
            end
        end
    end

    always_comb begin
        ld3  = iEN & v2_q;
        v3_d = iEN ? v2_q : v3_q;
        y_d  = y_q;
        for (int unsigned k = 0; k < BUT_NUM; k++) begin
            s0[k] = SW'(a2_q[k]) + SW'(t_q[k]);
            s1[k] = SW'(a2_q[k]) - SW'(t_q[k]);
            if (scale2_q) begin
                s0[k] = s0[k] >>> 1;
                s1[k] = s1[k] >>> 1;
            end
            sat[k] = out_of_range(s0[k]) | out_of_range(s1[k]);
            if (ld3) begin
                if (order2_q) begin
                    y_d[k*D_BIT +: D_BIT]             = clamp(s0[k]);
                    y_d[(BUT_NUM+k)*D_BIT +: D_BIT]   = clamp(s1[k]);
                end else begin
                    y_d[(2*k)*D_BIT +: D_BIT]         = clamp(s0[k]);
                    y_d[(2*k+1)*D_BIT +: D_BIT]       = clamp(s1[k]);
                end
            end
        end
        // Clear is ungated by iEN; a saturating beat landing on the same edge wins.
        ovf_d = ovf_q;
        if (iOVF_CLR) ovf_d = 1'b0;
        if (ld3 && (|sat)) ovf_d = 1'b1;
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            scale1_q <= 1'b0;
            order1_q <= 1'b0;
            scale2_q <= 1'b0;
            order2_q <= 1'b0;
            y_q      <= '0;
            ovf_q    <= 1'b0;
            for (int unsigned k = 0; k < BUT_NUM; k++) begin
                prod_q[k] <= '0;
                a1_q[k]   <= '0;
                a2_q[k]   <= '0;
                t_q[k]    <= '0;
            end
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            v3_q     <= v3_d;
            scale1_q <= scale1_d;
            order1_q <= order1_d;
            scale2_q <= scale2_d;
            order2_q <= order2_d;
            y_q      <= y_d;
            ovf_q    <= ovf_d;
            for (int unsigned k = 0; k < BUT_NUM; k++) begin
                prod_q[k] <= prod_d[k];
                a1_q[k]   <= a1_d[k];
                a2_q[k]   <= a2_d[k];
                t_q[k]    <= t_d[k];
            end
        end
    end

    assign oVALID = v3_q;
    assign oY     = y_q;
    assign oOVF   = ovf_q;

endmodule

// File: tb/tb_fht_but_array.sv
// Directed bench for fht_but_array (D_BIT=17, W_BIT=12, BUT_NUM=2) with hand-computed results.
module tb_fht_but_array;
    localparam int D  = 17;
    localparam int W  = 12;
    localparam int N  = 2;
    localparam int YW = 2 * N * D;

    logic clk = 1'b0;
    logic rst_n;
    logic en, valid, scale, order, ovf_clr;
    logic [N*D-1:0] a, b, c;
    logic [N*W-1:0] cs, sn;
    logic           o_valid;
    logic [YW-1:0]  o_y;
    logic           o_ovf;

    int total = 0;
    int bad   = 0;
    int out_cnt = 0;
    int bubble_mid = 0;

    always #5 clk = ~clk;

    fht_but_array #(.D_BIT(D), .W_BIT(W), .BUT_NUM(N)) dut (
        .iCLK(clk), .iRESET(rst_n), .iEN(en), .iVALID(valid), .iSCALE(scale), .iORDER(order),
        .iA(a), .iB(b), .iC(c), .iCOS(cs), .iSIN(sn), .iOVF_CLR(ovf_clr),
        .oVALID(o_valid), .oY(o_y), .oOVF(o_ovf)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [YW-1:0] obs, input logic [YW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_slots(input string tag, input int e0, input int e1, input int e2, input int e3);
        int ex[4];
        logic signed [D-1:0] s;
        ex = '{e0, e1, e2, e3};
        for (int j = 0; j < 2 * N; j++) begin
            s = o_y[j*D +: D];
            check($sformatf("%s_slot%0d", tag, j), 32'(s), ex[j]);
        end
    endtask

    task automatic check_beat(input string tag, input int e0, input int e1, input int e2, input int e3);
        check({tag, "_valid"}, 32'(o_valid), 1);
        check_slots(tag, e0, e1, e2, e3);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int k, input int av, input int bv, input int cv, input int cosv, input int sinv);
        a[k*D +: D]  = D'(av);
        b[k*D +: D]  = D'(bv);
        c[k*D +: D]  = D'(cv);
        cs[k*W +: W] = W'(cosv);
        sn[k*W +: W] = W'(sinv);
    endtask

    task automatic set_t1();
        set_lane(0, 100, 200, 0, 1024, 0);
        set_lane(1, 0, 0, 50, 0, 1024);
    endtask

    task automatic set_sat();
        set_lane(0, 65535, 65535, 0, 1024, 0);
        set_lane(1, -65536, -65536, 0, 1024, 0);
    endtask

    // Lane0: T=i, Y=(11i, 9i); lane1: T=2i, Y=(i, -3i)
    task automatic set_stream(input int i);
        set_lane(0, 10 * i, i, 0, 1024, 0);
        set_lane(1, -i, 0, 2 * i, 0, 1024);
    endtask

    // Launch one beat, flip the mode inputs afterwards, and stop one edge short of its output.
    task automatic launch(input logic s, input logic o);
        valid = 1'b1; scale = s; order = o;
        tick();
        valid = 1'b0; scale = ~s; order = ~o;
        tick();
        check("latency2_valid", 32'(o_valid), 0);
    endtask

    task automatic step_mon();
        logic en_edge, v_prev;
        en_edge = en;
        v_prev  = o_valid;
        tick();
        if (!en_edge) check("stall_valid", 32'(o_valid), 32'(v_prev));
        else if (o_valid) out_cnt++;
        else if (out_cnt > 0 && out_cnt < 8) bubble_mid++;
        if (out_cnt > 0) check_slots($sformatf("stream_b%0d", out_cnt), 11 * out_cnt, 9 * out_cnt, out_cnt, -3 * out_cnt);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; valid = 1'b0; scale = 1'b0; order = 1'b0; ovf_clr = 1'b0;
        a = '0; b = '0; c = '0; cs = '0; sn = '0;
        #12;
        check("reset_valid", 32'(o_valid), 0);
        check_vec("reset_y", o_y, '0);
        check("reset_ovf", 32'(o_ovf), 0);
        rst_n = 1'b1;
        tick();

        // Basic, scale, order
        set_t1();
        launch(1'b0, 1'b0); tick();
        check_beat("t1_nat", 300, -100, 50, -50);
        launch(1'b1, 1'b0); tick();
        check_beat("t1_scale", 150, -50, 25, -25);
        launch(1'b0, 1'b1); tick();
        check_beat("t1_split", 300, 50, -100, -50);

        // Rounding and floor halving
        set_lane(0, 0, 3, 0, 512, 0);
        set_lane(1, 0, -3, 0, 512, 0);
        launch(1'b0, 1'b0); tick();
        check_beat("t2_round", 2, -2, -1, 1);
        set_lane(0, 0, 1, 0, 1, 0);
        set_lane(1, -7, 0, 0, 0, 0);
        launch(1'b1, 1'b0); tick();
        check_beat("t2_floor", 0, 0, -4, -4);
        check("t2_ovf", 32'(o_ovf), 0);

        // Saturation and sticky flag
        set_sat();
        launch(1'b0, 1'b0);
        check("t3_ovf_early", 32'(o_ovf), 0);
        tick();
        check_beat("t3_sat", 65535, 0, -65536, 0);
        check("t3_ovf_set", 32'(o_ovf), 1);
        set_t1();
        launch(1'b0, 1'b0); tick();
        check_beat("t3_clean", 300, -100, 50, -50);
        check("t3_ovf_sticky", 32'(o_ovf), 1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("t3_ovf_clr", 32'(o_ovf), 0);
        set_sat();
        launch(1'b0, 1'b0);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("t3_set_wins", 32'(o_ovf), 1);
        en = 1'b0; ovf_clr = 1'b1; tick(); ovf_clr = 1'b0; en = 1'b1;
        check("t3_clr_no_en", 32'(o_ovf), 0);
        tick();

        // Streaming with a 2-cycle stall and a 1-cycle bubble
        scale = 1'b0; order = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            set_stream(i); valid = 1'b1; step_mon();
        end
        en = 1'b0; set_stream(99);
        step_mon(); step_mon();
        en = 1'b1;
        set_stream(4); step_mon();
        set_stream(5); step_mon();
        valid = 1'b0; set_stream(77); step_mon();
        valid = 1'b1;
        for (int i = 6; i <= 8; i++) begin
            set_stream(i); step_mon();
        end
        valid = 1'b0;
        repeat (4) step_mon();
        check("t4_count", out_cnt, 8);
        check("t4_bubble", bubble_mid, 1);
        check("t4_end_valid", 32'(o_valid), 0);

        // Asynchronous reset with beats in flight
        set_sat(); valid = 1'b1; tick();
        set_t1(); tick(); tick();
        check("t5_pre_ovf", 32'(o_ovf), 1);
        check("t5_pre_valid", 32'(o_valid), 1);
        #3 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(o_valid), 0);
        check_vec("t5_rst_y", o_y, '0);
        check("t5_rst_ovf", 32'(o_ovf), 0);
        valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t5_no_stale%0d", i), 32'(o_valid), 0);
        end
        set_t1();
        launch(1'b0, 1'b0); tick();
        check_beat("t5_new", 300, -100, 50, -50);

        // Per-beat mode changes
        set_t1();
        valid = 1'b1;
        scale = 1'b0; order = 1'b0; tick();
        scale = 1'b1; order = 1'b1; tick();
        scale = 1'b0; order = 1'b1; tick();
        check_beat("t6_b1", 300, -100, 50, -50);
        scale = 1'b1; order = 1'b0; tick();
        check_beat("t6_b2", 150, 25, -50, -25);
        valid = 1'b0; scale = 1'b0; order = 1'b0; tick();
        check_beat("t6_b3", 300, 50, -100, -50);
        tick();
        check_beat("t6_b4", 150, -50, 25, -25);
        tick();
        check("t6_drain_valid", 32'(o_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fht_but_array.md
# fht_but_array

Parametrised, fully pipelined array of BUT_NUM radix-2 Hartley butterflies for the FHT datapath. Each lane takes all three operands (sum-path point A, multiplier points B and C) plus one twiddle pair in a single beat, so a new butterfly set is accepted every enabled cycle. Per-beat options are optional 1/2 scaling, D_BIT saturation, a sticky overflow flag, and a selectable output ordering. It sits between the bank-read mixers and the bank-write logic of the FHT core.

## Interface
- D_BIT, 17, data word width (signed)
- W_BIT, 12, twiddle width (signed, W_BIT-2 fractional bits, 1.0 = 2^(W_BIT-2))
- BUT_NUM, 2, number of butterfly lanes (>=1)
- iCLK  in  1  clock; all state on rising edge
- iRESET  in  1  reset, asynchronous, active-low
- iEN  in  1  pipeline advance enable (0 = freeze all state)
- iVALID  in  1  input beat valid
- iSCALE  in  1  per-beat: divide results by 2
- iORDER  in  1  per-beat output order (0 natural, 1 split)
- iA, iB, iC  in  BUT_NUM*D_BIT each  lane k at [k*D_BIT +: D_BIT]
- iCOS, iSIN  in  BUT_NUM*W_BIT each  lane k at [k*W_BIT +: W_BIT]
- iOVF_CLR  in  1  clear sticky overflow
- oVALID  out  1  output beat valid
- oY  out  2*BUT_NUM*D_BIT  results, slot j at [j*D_BIT +: D_BIT]
- oOVF  out  1  sticky saturation flag

## Operation
- Per lane: P = B*COS + C*SIN, full precision (D_BIT+W_BIT+1 bits).
- T = (P + 2^(W_BIT-3)) >>> (W_BIT-2): round half up, arithmetic shift; keep D_BIT+3 bits.
- S0 = A + T, S1 = A - T, D_BIT+4 bits.
- iSCALE=1: S0, S1 >>> 1 (floor, no rounding). iSCALE=0: unchanged.
- Saturate each to [-2^(D_BIT-1), 2^(D_BIT-1)-1] giving Y0, Y1.
- Ordering, lane k:
  - iORDER=0: slot 2k = Y0, slot 2k+1 = Y1.
  - iORDER=1: slot k = Y0, slot BUT_NUM+k = Y1.
- iSCALE and iORDER are captured with the beat and travel with it. Changing them between beats takes effect on the next beat only.
- oOVF is set when any slot of an output beat saturates, on the edge where that beat enters the output register.
- oOVF is cleared by iOVF_CLR=1. Clear is independent of iEN. Set and clear in the same edge: set wins.

## Timing
- 3-stage pipeline.
  - S1: register products and the beat's mode bits.
  - S2: register rounded T and A.
  - S3: register saturated, reordered oY and oVALID.
- Latency is 3 enabled edges from the sampling edge (iVALID=1, iEN=1) to oVALID=1 with the result. Throughput is 1 beat per enabled cycle.
- iEN=0 freezes all data, mode and valid registers; oY and oVALID hold. Inputs are ignored on those edges.
- Downstream consumes one beat on each edge with oVALID=1 and iEN=1. A held beat is therefore never consumed twice.
- Bubbles (iEN=1, iVALID=0): the valid bit shifts as 0.
  - Stage data registers load only when their incoming valid is 1.
  - oY holds the last valid result while oVALID=0.
- Reset (async, any time, including mid-stream) clears all valid bits, data, mode bits and oOVF. oVALID=0, oY=0, oOVF=0. In-flight beats are discarded.
- First beat after reset release: result 3 enabled edges after sampling. No warm-up cycles.
- No backpressure output. The producer stalls via iEN only.

## Test plan
Parameters D_BIT=17, W_BIT=12, BUT_NUM=2 (1.0 = 1024).

1. Basic, scale and order:
   - Lane0 A=100, B=200, C=0, COS=1024, SIN=0. Lane1 A=0, B=0, C=50, COS=0, SIN=1024. iORDER=0.
   - 3 edges later: oVALID=1, slots = 300, -100, 50, -50.
   - Repeat with iSCALE=1: 150, -50, 25, -25.
   - Repeat with iORDER=1: 300, 50, -100, -50.
2. Rounding:
   - B=3, COS=512 -> T=2. B=-3, COS=512 -> T=-1 (A=0).
   - B=1, COS=1, SIN=0 -> T=0.
3. Saturation and flag:
   - A=65535, B=65535, COS=1024 -> Y0=65535 (clamped), Y1=0, oOVF=1.
   - oOVF holds across later clean beats until iOVF_CLR.
   - iOVF_CLR asserted on the same edge as a new saturating beat -> oOVF stays 1.
4. Streaming with stall and bubbles:
   - 8 back-to-back beats with iEN=0 for 2 cycles mid-stream and a 1-cycle iVALID=0 gap.
   - All 8 results emerge in order, none duplicated or lost.
   - oY and oVALID are frozen during the stall.
   - oY holds during the bubble with oVALID=0.
5. Reset mid-operation:
   - Assert iRESET low asynchronously (between clock edges) with 3 beats in flight.
   - Outputs clear immediately: oVALID=0, oY=0, oOVF=0.
   - After release, no stale beats appear. A new beat appears with latency 3.
6. Mode change per beat:
   - Alternate iSCALE/iORDER every beat.
   - Each output beat reflects its own captured mode bits.
